// File: rtl/pcs_loopback_elastic.sv
// Elastic loopback FIFO between pcs_rx and pcs_tx in the tx_par_clk domain.
// Drops inter-frame idles when nearly full and inserts idles (or an error word mid-frame) when empty.
module pcs_loopback_elastic #(
    parameter int IS_10G = 1,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int HI_WM  = DEPTH - 2,
    parameter int CNT_W  = 16,
    localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1,
    localparam int KEEP_W      = DATA_W / 8,
    localparam int FILL_W      = $clog2(DEPTH) + 1
) (
    input  logic                   tx_par_clk,
    input  logic                   nreset,
    input  logic                   rx_valid_i,
    input  logic                   rx_ctrl_i,
    input  logic                   rx_idle_i,
    input  logic [LANE0_CNT_N-1:0] rx_start_i,
    input  logic                   rx_term_i,
    input  logic                   rx_err_i,
    input  logic [DATA_W-1:0]      rx_data_i,
    input  logic [KEEP_W-1:0]      rx_keep_i,
    input  logic                   tx_ready_i,
    output logic                   tx_nreset_o,
    output logic                   tx_ctrl_o,
    output logic                   tx_idle_o,
    output logic                   tx_term_o,
    output logic                   tx_err_o,
    output logic [LANE0_CNT_N-1:0] tx_start_o,
    output logic [DATA_W-1:0]      tx_data_o,
    output logic [KEEP_W-1:0]      tx_keep_o,
    output logic [FILL_W-1:0]      fill_o,
    output logic [CNT_W-1:0]       ins_cnt_o,
    output logic [CNT_W-1:0]       del_cnt_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 4 + LANE0_CNT_N + KEEP_W + DATA_W;
    localparam int ERR_B   = DATA_W + KEEP_W;
    localparam int TERM_B  = ERR_B + 1;
    localparam int START_B = TERM_B + 1;
    localparam int IDLE_B  = ENTRY_W - 2;
    localparam logic [ENTRY_W-1:0] CTRL_ONLY = {1'b1, {(ENTRY_W-1){1'b0}}};
    localparam logic [ENTRY_W-1:0] IDLE_WORD = CTRL_ONLY | (ENTRY_W'(1) << IDLE_B);
    localparam logic [ENTRY_W-1:0] ERR_WORD  = CTRL_ONLY | (ENTRY_W'(1) << ERR_B);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [FILL_W-1:0]  fill_next;
    logic               wr_in_frame_reg;
    logic               rd_in_frame_reg;
    logic [1:0]         nreset_pipe_reg;
    logic [ENTRY_W-1:0] out_reg;
    logic [CNT_W-1:0]   ins_cnt_reg;
    logic [CNT_W-1:0]   del_cnt_reg;
    logic               overflow_reg;
    logic               underflow_reg;

    logic [ENTRY_W-1:0] rx_entry;
    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               full;
    logic               rd_en;
    logic               rx_deletable;
    logic               del_en;
    logic               ovf_drop;
    logic               wr_en;

    assign rx_entry = {rx_ctrl_i, rx_idle_i, rx_start_i, rx_term_i, rx_err_i, rx_keep_i, rx_data_i};

    always_comb begin
        head         = mem[rd_ptr_reg];
        empty        = (fill_reg == '0);
        full         = (fill_reg == FILL_W'(DEPTH));
        rd_en        = tx_ready_i && !empty;
        rx_deletable = rx_ctrl_i && rx_idle_i && !(|rx_start_i) && !rx_term_i && !rx_err_i;
        del_en       = rx_valid_i && rx_deletable && !wr_in_frame_reg
                       && (fill_reg >= FILL_W'(HI_WM));
        // A concurrent pop frees the slot, so a full FIFO still accepts when reading.
        ovf_drop     = rx_valid_i && !del_en && full && !rd_en;
        wr_en        = rx_valid_i && !del_en && !ovf_drop;
        fill_next    = fill_reg + FILL_W'(wr_en) - FILL_W'(rd_en);
    end

    always_ff @(posedge tx_par_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= rx_entry;
        end
    end

    always_ff @(posedge tx_par_clk) begin
        if (!nreset) begin
            nreset_pipe_reg <= 2'b00;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fill_reg        <= '0;
            wr_in_frame_reg <= 1'b0;
            rd_in_frame_reg <= 1'b0;
            out_reg         <= IDLE_WORD;
            ins_cnt_reg     <= '0;
            del_cnt_reg     <= '0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            nreset_pipe_reg <= {nreset_pipe_reg[0], 1'b1};
            fill_reg        <= fill_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (rx_term_i) begin
                    wr_in_frame_reg <= 1'b0;
                end else if (|rx_start_i) begin
                    wr_in_frame_reg <= 1'b1;
                end
            end
            if (del_en && (del_cnt_reg != '1)) begin
                del_cnt_reg <= del_cnt_reg + CNT_W'(1);
            end
            if (ovf_drop && !rx_deletable) begin
                overflow_reg <= 1'b1;
            end
            if (tx_ready_i) begin
                if (rd_en) begin
                    out_reg    <= head;
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    if (head[TERM_B]) begin
                        rd_in_frame_reg <= 1'b0;
                    end else if (|head[START_B +: LANE0_CNT_N]) begin
                        rd_in_frame_reg <= 1'b1;
                    end
                end else if (rd_in_frame_reg) begin
                    // Running dry mid-frame: poison the frame rather than pad it with idles.
                    out_reg         <= ERR_WORD;
                    underflow_reg   <= 1'b1;
                    rd_in_frame_reg <= 1'b0;
                end else begin
                    out_reg <= IDLE_WORD;
                    if (ins_cnt_reg != '1) begin
                        ins_cnt_reg <= ins_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign {tx_ctrl_o, tx_idle_o, tx_start_o, tx_term_o, tx_err_o, tx_keep_o, tx_data_o} = out_reg;
    assign tx_nreset_o = nreset_pipe_reg[1];
    assign fill_o      = fill_reg;
    assign ins_cnt_o   = ins_cnt_reg;
    assign del_cnt_o   = del_cnt_reg;
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;
endmodule

// File: doc/pcs_loopback_elastic.md
Name: pcs_loopback_elastic

Overview:
- Parametrised successor of the fixed 10G PCS loopback: carries decoded PCS RX words back to the PCS TX encoder through an elastic FIFO in the tx_par_clk domain.
- Absorbs RX valid gaps (gearbox slips) and TX ready back-pressure (TX gearbox stalls).
- Deletes idle words between frames when nearly full; inserts idle words when empty.
- Sits between pcs_rx, whose outputs are already in the tx_par_clk domain, and pcs_tx in the FPGA loopback test design. It also drives the delayed TX reset.

Parameters:
- IS_10G, 1, 1 selects 10G (LANE0_CNT_N=2); 0 selects 40G lane (LANE0_CNT_N=1).
- DATA_W, 64, data word width. KEEP_W=DATA_W/8.
- DEPTH, 8, FIFO entries. Power of 2, >=4.
- HI_WM, DEPTH-2, fill level at or above which inter-frame idles are deleted. Range 2..DEPTH-1.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- tx_par_clk  in  1  clock
- nreset  in  1  reset
- rx_valid_i  in  1  RX word valid
- rx_ctrl_i  in  1  RX word is control
- rx_idle_i  in  1  RX word is idle
- rx_start_i  in  LANE0_CNT_N  RX start per lane-0 position
- rx_term_i  in  1  RX terminate
- rx_err_i  in  1  RX error
- rx_data_i  in  DATA_W  RX data
- rx_keep_i  in  KEEP_W  RX byte keep
- tx_ready_i  in  1  pcs_tx consumed current output word
- tx_nreset_o  out  1  delayed reset to pcs_tx
- tx_ctrl_o, tx_idle_o, tx_term_o, tx_err_o  out  1 each  TX word fields
- tx_start_o  out  LANE0_CNT_N  TX start
- tx_data_o  out  DATA_W  TX data
- tx_keep_o  out  KEEP_W  TX keep
- fill_o  out  log2(DEPTH)+1  current FIFO occupancy
- ins_cnt_o  out  CNT_W  idles inserted, saturating
- del_cnt_o  out  CNT_W  idles deleted, saturating
- overflow_o  out  1  sticky: non-idle word lost
- underflow_o  out  1  sticky: FIFO empty while output mid-frame

Behaviour:
- Reset:
  - Reset is nreset, synchronous, active-low; clock tx_par_clk.
  - On reset: FIFO empty, fill_o=0, counters=0, sticky flags=0, in_frame flags=0.
  - Outputs hold the IDLE word: ctrl=1, idle=1, start/term/err=0, data=0, keep=0.
  - Reset mid-operation discards all FIFO contents next cycle.
- tx_nreset_o:
  - Two-flop delay of nreset: low during reset, high the 2nd rising edge after nreset goes high.
- Entry:
  - One entry is {ctrl, idle, start, term, err, keep, data}.
  - Deletable idle word: rx ctrl=1, idle=1, start=0, term=0, err=0.
- Write-side frame tracker wr_in_frame:
  - Set on an accepted word with |start; cleared on an accepted word with term.
  - If start and term arrive in the same word, term wins and the flag is cleared.
- Write side, evaluated when rx_valid_i=1, in priority order:
  1. Word is a deletable idle, wr_in_frame=0, and fill>=HI_WM: drop the word; del_cnt++.
  2. FIFO full and no read this cycle: drop the word; overflow_o=1 unless the word is a deletable idle.
  3. Otherwise write the word.
- A simultaneous read frees a slot, so a write to a full FIFO with a concurrent read is accepted.
- Read side, when tx_ready_i=1:
  - FIFO non-empty: output registers load the head entry and pop it.
  - FIFO empty: output registers load the IDLE word; ins_cnt++.
  - If rd_in_frame=1 when empty, load an error word instead (ctrl=1, err=1, idle=0), set underflow_o=1, and clear rd_in_frame.
  - rd_in_frame tracks the output stream with the same rules as wr_in_frame.
- tx_ready_i=0: outputs and FIFO head hold.
- No write-to-read bypass: minimum latency is write at edge N, word visible on the outputs after edge N+1 given tx_ready_i=1.
- Counters saturate at 2^CNT_W-1.
- Sticky flags clear only on reset.
- fill_o is the registered occupancy after this cycle's push/pop.

Test Plan:
- Reset: hold nreset=0 for 3 cycles, then release → outputs hold IDLE, fill_o=0, tx_nreset_o=0 for 2 cycles then 1.
- Passthrough: tx_ready_i=1, rx_valid_i=1, a 10-word frame (start, 8 data with data=i, term keep=0x0F) → identical sequence out 2 cycles later; ins/del=0.
- Idle deletion: tx_ready_i toggling 1-of-2, continuous valid, DEPTH=8 → fill never exceeds 7; only inter-frame idles are dropped; del_cnt equals dropped count; no overflow.
- Idle insertion: rx_valid_i=0 for 5 cycles between frames → 5 IDLE out; ins_cnt=5 (plus the initial empty reads); frame contents unaltered.
- Overflow: tx_ready_i=0 and 12 data words mid-frame → fill_o=8 and overflow_o=1; with simultaneous read on full, the write is accepted.
- Underflow: a frame starts, then rx_valid_i=0 mid-frame until empty → error word out, underflow_o=1; reset during the frame → FIFO cleared, flags 0.
